// File: rtl/bus_sequencer.sv
// Host-to-controller bus sequencer: a tagged byte FIFO is drained into registered
// enable/data_out commands; each IR load is followed by an execute cycle and a result capture.
module bus_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_tag,
  input  logic [7:0] in_data,
  output logic [1:0] enable,
  output logic [7:0] data_out,
  input  logic [7:0] result_in,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       busy,
  output logic [7:0] instr_count,
  output logic [7:0] drop_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e        state_q;
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [1:0]    enable_q;
  logic [7:0]    data_out_q;
  logic          res_valid_q;
  logic [7:0]    res_data_q;
  logic [7:0]    instr_count_q;
  logic [7:0]    drop_count_q;

  logic          accept_d;
  logic          push_d;
  logic          drop_d;
  logic          pop_d;
  logic [9:0]    head_d;

  assign in_ready    = (count_q < FULL);
  assign busy        = (count_q != '0) || (state_q != IDLE);
  assign enable      = enable_q;
  assign data_out    = data_out_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign instr_count = instr_count_q;
  assign drop_count  = drop_count_q;

  // Illegal tags complete the handshake but never occupy a FIFO slot.
  always_comb begin
    accept_d = in_valid && in_ready;
    push_d   = accept_d && (in_tag != 2'b00);
    drop_d   = accept_d && (in_tag == 2'b00);
    pop_d    = ((state_q == IDLE) || (state_q == CAPTURE)) && (count_q != '0);
    head_d   = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (push_d) begin
      mem_q[wr_ptr_q] <= {in_tag, in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      enable_q      <= '0;
      data_out_q    <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      instr_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      if (push_d) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_d) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_d, pop_d})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      if (drop_d && (drop_count_q != 8'hFF)) begin
        drop_count_q <= drop_count_q + 8'd1;
      end

      res_valid_q <= 1'b0;
      case (state_q)
        EXEC: begin
          enable_q <= 2'b00;
          state_q  <= CAPTURE;
        end
        IDLE, CAPTURE: begin
          // CAPTURE retires the previous instruction and may issue the next head in the same cycle.
          if (state_q == CAPTURE) begin
            res_data_q    <= result_in;
            res_valid_q   <= 1'b1;
            instr_count_q <= instr_count_q + 8'd1;
          end
          if (pop_d) begin
            enable_q   <= head_d[9:8];
            data_out_q <= head_d[7:0];
            state_q    <= (head_d[9:8] == 2'b11) ? EXEC : IDLE;
          end else begin
            enable_q <= 2'b00;
            state_q  <= IDLE;
          end
        end
        default: begin
          enable_q <= 2'b00;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer: stimulus queues expected issues/results,
// a negedge monitor pops and compares whenever the DUT issues a command or a result.
module tb_bus_sequencer;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_tag = '0;
  logic [7:0] in_data = '0;
  logic [1:0] enable;
  logic [7:0] data_out;
  logic [7:0] result_in = '0;
  logic       res_valid;
  logic [7:0] res_data;
  logic       busy;
  logic [7:0] instr_count;
  logic [7:0] drop_count;

  bus_sequencer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_tag     (in_tag),
    .in_data    (in_data),
    .enable     (enable),
    .data_out   (data_out),
    .result_in  (result_in),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .busy       (busy),
    .instr_count(instr_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] exp_q[$];
  logic [7:0] res_q[$];
  int         ir_cyc_q[$];
  int         issue_log[$];
  int         ir_log[$];
  bit         exec_pending = 1'b0;
  logic [9:0] exp_issue;
  int         b;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input int act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got 0x%0h, expected nothing (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: every nonzero enable is one issued command; res_valid is one retired instruction.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      res_q.delete();
      ir_cyc_q.delete();
      exec_pending = 1'b0;
    end else begin
      if (exec_pending) begin
        check("exec_cycle_enable", int'(enable), 0);
        exec_pending = 1'b0;
      end
      if (enable != 2'b00) begin
        issue_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          flag("unexpected_issue", int'({enable, data_out}));
        end else begin
          exp_issue = exp_q.pop_front();
          check("issue", int'({enable, data_out}), int'(exp_issue));
        end
        if (enable == 2'b11) begin
          exec_pending = 1'b1;
          ir_cyc_q.push_back(cyc);
          ir_log.push_back(cyc);
        end
      end
      if (res_valid) begin
        if (res_q.size() == 0 || ir_cyc_q.size() == 0) begin
          flag("unexpected_res_valid", int'(res_data));
        end else begin
          check("res_data", int'(res_data), int'(res_q.pop_front()));
          check("res_latency", cyc - ir_cyc_q.pop_front(), 2);
        end
      end
    end
  end

  task automatic push(input logic [1:0] tag, input logic [7:0] d);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("push_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    in_tag   = tag;
    in_data  = d;
    if (tag != 2'b00) exp_q.push_back({tag, d});
    if (tag == 2'b11) res_q.push_back(result_in);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_enable", int'(enable), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_instr_count", int'(instr_count), 0);
    check("rst_drop_count", int'(drop_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", int'(in_ready), 1);

    // R0, R1, IR frame; result 0x08
    result_in = 8'h08;
    b = issue_log.size();
    push(2'b01, 8'h05);
    push(2'b10, 8'h03);
    push(2'b11, 8'h11);
    wait_idle();
    check("t1_issue_count", issue_log.size() - b, 3);
    if (issue_log.size() - b == 3) begin
      check("t1_gap0", issue_log[b+1] - issue_log[b], 1);
      check("t1_gap1", issue_log[b+2] - issue_log[b+1], 1);
    end
    check("t1_res_data", int'(res_data), 8'h08);
    check("t1_instr_count", int'(instr_count), 1);

    // Fill the FIFO with IR frames (pop rate one per two cycles); 8th offer is refused
    result_in = 8'h77;
    for (int i = 0; i < 8; i++) begin
      check("t2_in_ready", int'(in_ready), (i < 7) ? 1 : 0);
      in_valid = 1'b1;
      in_tag   = 2'b11;
      in_data  = (i < 7) ? 8'(8'h30 + i) : 8'hEE;
      if (i < 7) begin
        exp_q.push_back({2'b11, in_data});
        res_q.push_back(result_in);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle();
    check("t2_instr_count", int'(instr_count), 8);

    // Illegal-tag drops saturate at 255
    in_valid = 1'b1;
    in_tag   = 2'b00;
    in_data  = 8'hAA;
    repeat (10) @(posedge clk);
    #1;
    check("t3_drop_10", int'(drop_count), 10);
    check("t3_busy_mid", int'(busy), 0);
    repeat (290) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("t3_drop_sat", int'(drop_count), 255);
    check("t3_enable", int'(enable), 0);
    check("t3_instr_count", int'(instr_count), 8);

    // Back-to-back IR frames
    result_in = 8'h99;
    b = ir_log.size();
    push(2'b11, 8'h21);
    push(2'b11, 8'h12);
    wait_idle();
    check("t4_ir_count", ir_log.size() - b, 2);
    if (ir_log.size() - b == 2) check("t4_ir_gap", ir_log[b+1] - ir_log[b], 2);
    check("t4_instr_count", int'(instr_count), 10);

    // Reset during EXEC with a byte still queued
    result_in = 8'h44;
    push(2'b11, 8'h44);
    push(2'b01, 8'h55);
    check("t5_ir_issued", int'(enable), 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_enable", int'(enable), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_instr", int'(instr_count), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t5_instr_count", int'(instr_count), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_in_ready", int'(in_ready), 1);
    check("t5_res_data", int'(res_data), 0);
    check("t5_data_out", int'(data_out), 0);
    check("t5_drop_count", int'(drop_count), 0);

    // 256 IR frames wrap the instruction counter
    result_in = 8'h5A;
    for (int i = 0; i < 255; i++) push(2'b11, 8'(i));
    wait_idle();
    check("t6_instr_255", int'(instr_count), 255);
    push(2'b11, 8'hFF);
    wait_idle();
    check("t6_instr_wrap", int'(instr_count), 0);
    check("t6_res_data", int'(res_data), 8'h5A);

    check("end_exp_q_empty", exp_q.size(), 0);
    check("end_res_q_empty", res_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
